// File: rtl/pb_pkg.sv
// Shared constants and channel state encoding for the pushbutton conditioner.
package pb_pkg;

  localparam int unsigned PB_DB_CYCLES_50M  = 500_000;     // 10 ms
  localparam int unsigned PB_RPT_DELAY_50M  = 25_000_000;  // 0.5 s
  localparam int unsigned PB_RPT_PERIOD_50M = 5_000_000;   // 0.1 s

  typedef logic [1:0] pb_state_t;

  localparam pb_state_t ST_IDLE   = 2'd0;
  localparam pb_state_t ST_DELAY  = 2'd1;
  localparam pb_state_t ST_REPEAT = 2'd2;

  // Counter width able to hold values 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pb_channel.sv
// One pushbutton: 2-flop synchroniser, debounce, press/release pulses and
// a hold-to-repeat step generator.
module pb_channel
  import pb_pkg::*;
#(
  parameter int unsigned DB_CYCLES  = PB_DB_CYCLES_50M,
  parameter int unsigned RPT_DELAY  = PB_RPT_DELAY_50M,
  parameter int unsigned RPT_PERIOD = PB_RPT_PERIOD_50M
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic pb_n_i,
  input  logic rpt_en_i,
  output logic pressed_o,
  output logic press_pulse_o,
  output logic release_pulse_o,
  output logic step_o
);

  localparam int unsigned DBW    = $clog2(DB_CYCLES);
  localparam int unsigned HC_MAX = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
  localparam int unsigned HCW    = cnt_w(HC_MAX);

  localparam logic [DBW-1:0] DB_LAST  = DBW'(DB_CYCLES - 1);
  localparam logic [HCW-1:0] DLY_LAST = HCW'(RPT_DELAY - 1);
  localparam logic [HCW-1:0] PER_LAST = HCW'(RPT_PERIOD - 1);

  // Synchroniser holds the active-high sense; 0 is "released".
  logic           sync1_q, sync2_q;
  logic           pressed_q, pressed_d;
  logic           press_q, press_d;
  logic           rel_q, rel_d;
  logic           step_q, step_d;
  logic [DBW-1:0] dbc_q, dbc_d;
  logic [HCW-1:0] hc_q, hc_d;
  pb_state_t      st_q, st_d;

  always_comb begin
    dbc_d     = dbc_q;
    pressed_d = pressed_q;
    press_d   = 1'b0;
    rel_d     = 1'b0;
    if (sync2_q == pressed_q) begin
      dbc_d = '0;
    end else if (dbc_q == DB_LAST) begin
      pressed_d = sync2_q;
      dbc_d     = '0;
      press_d   = sync2_q;
      rel_d     = ~sync2_q;
    end else begin
      dbc_d = dbc_q + 1'b1;
    end
  end

  // A release always wins over a repeat tick falling in the same cycle.
  always_comb begin
    st_d   = st_q;
    hc_d   = hc_q;
    step_d = 1'b0;
    if (rel_d) begin
      st_d = ST_IDLE;
      hc_d = '0;
    end else begin
      case (st_q)
        ST_IDLE: begin
          if (press_d) begin
            st_d   = ST_DELAY;
            hc_d   = '0;
            step_d = 1'b1;
          end
        end
        ST_DELAY: begin
          if (!rpt_en_i) begin
            hc_d = '0;
          end else if (hc_q == DLY_LAST) begin
            st_d   = ST_REPEAT;
            hc_d   = '0;
            step_d = 1'b1;
          end else begin
            hc_d = hc_q + 1'b1;
          end
        end
        ST_REPEAT: begin
          if (!rpt_en_i) begin
            st_d = ST_DELAY;
            hc_d = '0;
          end else if (hc_q == PER_LAST) begin
            hc_d   = '0;
            step_d = 1'b1;
          end else begin
            hc_d = hc_q + 1'b1;
          end
        end
        default: begin
          st_d = ST_IDLE;
          hc_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      pressed_q <= 1'b0;
      press_q   <= 1'b0;
      rel_q     <= 1'b0;
      step_q    <= 1'b0;
      dbc_q     <= '0;
      hc_q      <= '0;
      st_q      <= ST_IDLE;
    end else begin
      sync1_q   <= ~pb_n_i;
      sync2_q   <= sync1_q;
      pressed_q <= pressed_d;
      press_q   <= press_d;
      rel_q     <= rel_d;
      step_q    <= step_d;
      dbc_q     <= dbc_d;
      hc_q      <= hc_d;
      st_q      <= st_d;
    end
  end

  assign pressed_o       = pressed_q;
  assign press_pulse_o   = press_q;
  assign release_pulse_o = rel_q;
  assign step_o          = step_q;

endmodule

// File: rtl/pb_conditioner.sv
// Conditions NB independent active-low pushbuttons into clean levels,
// press/release pulses and auto-repeating step pulses.
module pb_conditioner
  import pb_pkg::*;
#(
  parameter int unsigned NB         = 4,
  parameter int unsigned DB_CYCLES  = PB_DB_CYCLES_50M,
  parameter int unsigned RPT_DELAY  = PB_RPT_DELAY_50M,
  parameter int unsigned RPT_PERIOD = PB_RPT_PERIOD_50M
) (
  input  logic          CLK50,
  input  logic          rst,
  input  logic [NB-1:0] pb_n,
  input  logic [NB-1:0] rpt_en,
  output logic [NB-1:0] pressed,
  output logic [NB-1:0] press_pulse,
  output logic [NB-1:0] release_pulse,
  output logic [NB-1:0] step
);

  for (genvar b = 0; b < NB; b++) begin : g_ch
    pb_channel #(
      .DB_CYCLES (DB_CYCLES),
      .RPT_DELAY (RPT_DELAY),
      .RPT_PERIOD(RPT_PERIOD)
    ) u_ch (
      .clk_i          (CLK50),
      .rst_i          (rst),
      .pb_n_i         (pb_n[b]),
      .rpt_en_i       (rpt_en[b]),
      .pressed_o      (pressed[b]),
      .press_pulse_o  (press_pulse[b]),
      .release_pulse_o(release_pulse[b]),
      .step_o         (step[b])
    );
  end

endmodule

// File: tb/tb_pb_conditioner.sv
// Bench for pb_conditioner: directed scenarios plus random bouncing buttons,
// checked against an event-level reference model through a scoreboard queue.
module tb_pb_conditioner;

  localparam int NB = 4;
  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RP = 3;

  logic          CLK50 = 1'b0;
  logic          rst = 1'b1;
  logic [NB-1:0] pb_n = '1;
  logic [NB-1:0] rpt_en = '0;
  logic [NB-1:0] pressed, press_pulse, release_pulse, step;

  pb_conditioner #(
    .NB(NB), .DB_CYCLES(DB), .RPT_DELAY(RD), .RPT_PERIOD(RP)
  ) dut (
    .CLK50        (CLK50),
    .rst          (rst),
    .pb_n         (pb_n),
    .rpt_en       (rpt_en),
    .pressed      (pressed),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .step         (step)
  );

  initial forever #5 CLK50 = ~CLK50;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int passes = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
  endfunction

  typedef struct {
    int            cyc;
    logic [NB-1:0] pr;
    logic [NB-1:0] rl;
    logic [NB-1:0] st;
  } ev_t;

  ev_t exp_q[$];

  // Reference model: a button is accepted once the synchronised input has
  // disagreed with the accepted level for DB consecutive edges; repeats come
  // after RD enabled edges of holding, then every RP enabled edges.
  int            cyc = 0;
  logic [NB-1:0] m_r1, m_r2, m_lvl, m_held, exp_lvl;
  int            m_run[NB], m_cnt[NB], m_tgt[NB];
  logic [NB-1:0] m_pr, m_rl, m_st;
  logic          m_s;

  initial begin
    m_r1 = '1; m_r2 = '1; m_lvl = '0; m_held = '0; exp_lvl = '0;
    forever begin
      @(posedge CLK50);
      cyc++;
      if (rst) begin
        m_r1 = '1; m_r2 = '1; m_lvl = '0; m_held = '0;
        for (int b = 0; b < NB; b++) begin
          m_run[b] = 0; m_cnt[b] = 0; m_tgt[b] = RD;
        end
      end else begin
        m_pr = '0; m_rl = '0; m_st = '0;
        for (int b = 0; b < NB; b++) begin
          m_s = ~m_r2[b];
          if (m_s != m_lvl[b]) begin
            m_run[b]++;
            if (m_run[b] == DB) begin
              m_run[b] = 0;
              m_lvl[b] = m_s;
              if (m_s) m_pr[b] = 1'b1;
              else     m_rl[b] = 1'b1;
            end
          end else begin
            m_run[b] = 0;
          end
          if (m_pr[b]) begin
            m_st[b] = 1'b1; m_held[b] = 1'b1; m_cnt[b] = 0; m_tgt[b] = RD;
          end else if (m_rl[b]) begin
            m_held[b] = 1'b0;
          end else if (m_held[b]) begin
            if (rpt_en[b]) begin
              m_cnt[b]++;
              if (m_cnt[b] == m_tgt[b]) begin
                m_st[b] = 1'b1; m_cnt[b] = 0; m_tgt[b] = RP;
              end
            end else begin
              m_cnt[b] = 0; m_tgt[b] = RD;
            end
          end
        end
        m_r2 = m_r1;
        m_r1 = pb_n;
        if ((m_pr | m_rl | m_st) != '0)
          exp_q.push_back('{cyc: cyc, pr: m_pr, rl: m_rl, st: m_st});
      end
      exp_lvl = m_lvl;
    end
  end

  // Monitor: pops the scoreboard whenever the DUT shows any pulse.
  int  n_press[NB], n_rel[NB], n_step[NB];
  ev_t e;

  initial begin
    for (int b = 0; b < NB; b++) begin
      n_press[b] = 0; n_rel[b] = 0; n_step[b] = 0;
    end
    forever begin
      @(negedge CLK50);
      if (!rst) begin
        chk("pressed_level", 32'(pressed), 32'(exp_lvl));
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
          checks++;
          $display("FAIL missed_event: cycle %0d got no pulse expected pr=%b rl=%b st=%b",
                   exp_q[0].cyc, exp_q[0].pr, exp_q[0].rl, exp_q[0].st);
          void'(exp_q.pop_front());
        end
        if ((press_pulse | release_pulse | step) != '0) begin
          if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            e = exp_q.pop_front();
            chk("press_pulse", 32'(press_pulse), 32'(e.pr));
            chk("release_pulse", 32'(release_pulse), 32'(e.rl));
            chk("step", 32'(step), 32'(e.st));
          end else begin
            checks++;
            $display("FAIL unexpected_pulse: cycle %0d got pr=%b rl=%b st=%b expected none",
                     cyc, press_pulse, release_pulse, step);
          end
        end
        for (int b = 0; b < NB; b++) begin
          n_press[b] += int'(press_pulse[b]);
          n_rel[b]   += int'(release_pulse[b]);
          n_step[b]  += int'(step[b]);
        end
      end
    end
  end

  int s_press[NB], s_rel[NB], s_step[NB];

  task automatic cyc_wait(input int n);
    repeat (n) @(negedge CLK50);
    #1;
  endtask

  task automatic snap();
    for (int b = 0; b < NB; b++) begin
      s_press[b] = n_press[b]; s_rel[b] = n_rel[b]; s_step[b] = n_step[b];
    end
  endtask

  initial begin
    #1;
    chk("reset_pressed", 32'(pressed), 32'(0));
    chk("reset_press_pulse", 32'(press_pulse), 32'(0));
    chk("reset_release_pulse", 32'(release_pulse), 32'(0));
    chk("reset_step", 32'(step), 32'(0));
    cyc_wait(3);
    rst = 1'b0;
    cyc_wait(3);

    // Clean press of bit 1, no auto-repeat.
    snap();
    pb_n = 4'b1101; cyc_wait(36);
    pb_n = 4'b1111; cyc_wait(15);
    chk("b1_press_count", 32'(n_press[1] - s_press[1]), 32'(1));
    chk("b1_step_count", 32'(n_step[1] - s_step[1]), 32'(1));
    chk("b1_release_count", 32'(n_rel[1] - s_rel[1]), 32'(1));

    // Bouncing bit 2 settles into a single press.
    snap();
    pb_n = 4'b1011; cyc_wait(2);
    pb_n = 4'b1111; cyc_wait(1);
    pb_n = 4'b1011; cyc_wait(3);
    pb_n = 4'b1111; cyc_wait(1);
    pb_n = 4'b1011; cyc_wait(20);
    pb_n = 4'b1111; cyc_wait(12);
    chk("b2_bounce_press_count", 32'(n_press[2] - s_press[2]), 32'(1));

    // Bit 3 held with repeat: steps at +0,+10,+13,...,+28, release at +30.
    snap();
    rpt_en = 4'b1000; pb_n = 4'b0111; cyc_wait(30);
    pb_n = 4'b1111; cyc_wait(15);
    chk("b3_repeat_step_count", 32'(n_step[3] - s_step[3]), 32'(8));

    // Repeat disabled at +12, re-enabled at +15: steps at +0,+10,+25,+28.
    snap();
    pb_n = 4'b0111; cyc_wait(18);
    rpt_en = 4'b0000; cyc_wait(3);
    rpt_en = 4'b1000; cyc_wait(10);
    pb_n = 4'b1111; cyc_wait(12);
    chk("b3_rpt_toggle_step_count", 32'(n_step[3] - s_step[3]), 32'(4));

    // Bits 1 and 2 together.
    snap();
    rpt_en = 4'b0000; pb_n = 4'b1001; cyc_wait(10);
    pb_n = 4'b1111; cyc_wait(12);
    chk("b1_simul_press", 32'(n_press[1] - s_press[1]), 32'(1));
    chk("b2_simul_press", 32'(n_press[2] - s_press[2]), 32'(1));

    // Reset mid-repeat with bit 3 held.
    rpt_en = 4'b1000; pb_n = 4'b0111; cyc_wait(20);
    chk("pre_reset_pressed", 32'(pressed), 32'(4'b1000));
    rst = 1'b1; #1;
    chk("async_rst_pressed", 32'(pressed), 32'(0));
    chk("async_rst_press_pulse", 32'(press_pulse), 32'(0));
    chk("async_rst_release_pulse", 32'(release_pulse), 32'(0));
    chk("async_rst_step", 32'(step), 32'(0));
    cyc_wait(2);
    rst = 1'b0;
    snap();
    cyc_wait(10);
    chk("post_rst_press_count", 32'(n_press[3] - s_press[3]), 32'(1));
    chk("post_rst_step_count", 32'(n_step[3] - s_step[3]), 32'(1));
    pb_n = 4'b1111; cyc_wait(12);

    // Random bouncing buttons, toggling enables and occasional resets.
    for (int i = 0; i < 2000; i++) begin
      for (int b = 0; b < NB; b++) begin
        if ($urandom_range(0, 99) < 8) pb_n[b] = ~pb_n[b];
        if ($urandom_range(0, 99) < 2) rpt_en[b] = ~rpt_en[b];
      end
      if ($urandom_range(0, 999) == 0) begin
        rst = 1'b1; cyc_wait(2); rst = 1'b0;
      end
      cyc_wait(1);
    end

    pb_n = 4'b1111; cyc_wait(25);
    chk("queue_drained", 32'(exp_q.size()), 32'(0));
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/pb_conditioner.md
# pb_conditioner

Front-end conditioning for the active-low board pushbuttons before they reach the clock/alarm control logic. Each button is synchronised to `CLK50`, debounced, and turned into a clean active-high level, one-cycle press and release pulses, and a `step` pulse with hold-to-auto-repeat. With auto-repeat, a held minute or hour button sweeps its value. The control logic consumes `step` directly and no longer keeps per-button "can press" flags.

## Interface
- `NB`, 4: number of buttons.
- `DB_CYCLES`, 500_000: debounce window, 10 ms at 50 MHz; minimum 2.
- `RPT_DELAY`, 25_000_000: hold time from accepted press to first repeat `step`, 0.5 s.
- `RPT_PERIOD`, 5_000_000: interval between subsequent repeat `step`s, 0.1 s; minimum 1.
- `CLK50`  in  1  system clock, 50 MHz.
- `rst`  in  1  reset, asynchronous, active-high.
- `pb_n`  in  NB  raw pushbuttons, active-low, asynchronous to `CLK50`.
- `rpt_en`  in  NB  per-button auto-repeat enable, synchronous.
- `pressed`  out  NB  debounced level, 1 = held.
- `press_pulse`  out  NB  one-cycle pulse on accepted press.
- `release_pulse`  out  NB  one-cycle pulse on accepted release.
- `step`  out  NB  one-cycle pulse on accepted press, and on each auto-repeat tick.

## Operation
- Buttons are fully independent. Simultaneous activity on several buttons produces independent outputs in the same cycles.

**Synchroniser**
- Two-flop synchroniser per bit, inverted to active-high (`s`).
- Synchroniser flops reset to "released".

**Debounce**
- Counter `dbc`, width `$clog2(DB_CYCLES)`.
- While `s == pressed`, `dbc` is cleared.
- While `s != pressed`, `dbc` increments.
- When `dbc == DB_CYCLES-1` and `s != pressed`:
  - `pressed <= s` and `dbc <= 0`.
  - `press_pulse` or `release_pulse` is set for exactly one cycle, registered.
- Any bounce back to the current stable level before the window completes clears `dbc`. Glitches shorter than `DB_CYCLES` cycles produce no output.

**Channel FSM**, states IDLE, DELAY, REPEAT
- IDLE → DELAY on an accepted press. `step` pulses with `press_pulse`, and hold counter `hc` is cleared.
- DELAY:
  - `hc` increments while `rpt_en` = 1.
  - At `hc == RPT_DELAY-1`: `step` pulses, `hc <= 0`, go to REPEAT.
- REPEAT:
  - `hc` increments.
  - At `hc == RPT_PERIOD-1`: `step` pulses and `hc <= 0`.
- Any accepted release → IDLE and `hc <= 0`. No `step` on release.
- `rpt_en` = 0 in DELAY or REPEAT: `hc` is held at 0, the state returns to DELAY, and no repeat `step`s occur. Re-enabling while still held restarts the full `RPT_DELAY`, with no immediate `step`.
- `rpt_en` has no effect on the initial press `step`.

**Reset**
- All outputs, counters and FSMs go to 0/IDLE immediately on `rst`, including mid-debounce and mid-repeat.
- A button held through reset deassertion is treated as a new press: `press_pulse` and `step` fire after the normal latency.

## Timing
- Reset values: `pressed`, `press_pulse`, `release_pulse`, `step` all 0.
- Press latency: `pb_n` low and stable, first sampled at edge k. `pressed`, `press_pulse` and `step` are 1 in the cycle after edge k+1+DB_CYCLES. Release latency is the same.
- `press_pulse`, `release_pulse` and `step` are exactly one cycle wide. The press-cycle `step` coincides with `press_pulse`.
- First repeat `step` comes `RPT_DELAY` cycles after the press `step`. Each further `step` comes `RPT_PERIOD` cycles after the previous one.
- Release on the cycle a repeat tick is due: the release wins, and no `step` is produced.
- Counters never wrap. They are compared and cleared at their terminal value.

## Structure
- Shared package `pb_pkg` holds:
  - the default cycle constants for 50 MHz (10 ms, 0.5 s, 0.1 s);
  - the channel state encoding (IDLE=0, DELAY=1, REPEAT=2).
- One sub-module, `pb_channel`: synchroniser, debounce, FSM and counters for a single button, instantiated `NB` times by generate in `pb_conditioner`.

## Test plan
Bench parameters: DB_CYCLES=4, RPT_DELAY=10, RPT_PERIOD=3, NB=4.
- Clean press of bit 1 (`pb_n` = 4'b1101) held 30 cycles, `rpt_en` = 0 → `pressed[1]`=1 after 6 edges. `press_pulse[1]` and `step[1]` are each 1 cycle. No further `step`s. `release_pulse[1]` comes 6 edges after the release.
- Bounce on bit 2: 0 for 2 cycles, 1 for 1, 0 for 3, 1 for 1, then 0 stable → exactly one `press_pulse[2]`, 6 edges after the final low edge. No intermediate pulses.
- Hold bit 3 for 30 cycles after acceptance, `rpt_en[3]` = 1 → `step[3]` at press +0, +10, +13, +16, +19, +22, +25, +28. None after release.
- `rpt_en[3]` dropped at press+12, raised at press+15 while held → no `step` at +13. Next `step` at +25.
- Bits 1 and 2 pressed in the same cycle → `press_pulse` = 4'b0110 in one cycle.
- `rst` pulse mid-repeat while bit 3 stays held → all outputs 0 asynchronously. After deassertion, a fresh `press_pulse[3]` and `step[3]` after 6 edges.
